l1_dcache_responder: RTL and testbench
======================================

Name: l1_dcache_responder

Overview:
- Responder end of the pipeline data-memory port: accepts the mem stage's read/write requests (word address, write data, 2-bit byte mask) and answers with mem_resp/mem_rdata.
- Direct-mapped, write-back, write-allocate L1 data cache.
- Fronts a 128-bit line interface toward L2/physical memory.
- Emits single-cycle hit/miss event pulses for the mem stage's performance counters.

Parameters:
- NUM_SETS, 8, number of lines; power of two, 2..64; index width IW = log2(NUM_SETS).
- Line size is fixed: 16 bytes (8 words); offset = addr[3:1]; index = addr[3+IW:4]; tag = addr[15:4+IW].

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_address  in  16  byte address from mem stage (bit0 ignored for word select)
- mem_wdata  in  16  write data, already lane-aligned by requester
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  2  write lane mask (bit1 = [15:8])
- mem_rdata  out  16  read data, valid when mem_resp=1
- mem_resp  out  1  request complete
- pmem_address  out  16  line address to L2, low 4 bits zero
- pmem_wdata  out  128  victim line data
- pmem_rdata  in  128  fill line data
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_resp  in  1  L2 completion
- dcache_hit  out  1  one-cycle pulse per hit response
- dcache_miss  out  1  one-cycle pulse per miss detection

Behaviour:
- Reset (async): all valid and dirty bits cleared, state S_IDLE. All outputs 0, including mem_resp, pmem_read/write, and the pulses. Data/tag arrays need no reset.
- mem_read and mem_write both high: treated as a write.
- S_IDLE:
  - Request and (valid & tag match) = hit.
  - Hit: mem_resp=1 combinationally in the same cycle; mem_rdata = word[offset]; dcache_hit=1.
  - Write hit: enabled lanes update at the next posedge and dirty is set. byte_enable=00 updates nothing but still responds.
  - Miss with clean or invalid victim: -> S_ALLOCATE.
  - Miss with dirty victim: -> S_WRITEBACK.
  - Either miss: dcache_miss=1 for that one cycle only; mem_resp=0.
- S_WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 4'b0}; pmem_wdata = victim line.
  - On pmem_resp: clear dirty, -> S_ALLOCATE.
- S_ALLOCATE:
  - pmem_read=1; pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: line <= pmem_rdata, tag written, valid=1, dirty=0, -> S_IDLE.
  - The request then hits in the following cycle (a miss costs L2 latency + 1 cycle; hit pulse fires then).
- Request dropped mid-miss: the writeback/fill still completes; state returns to S_IDLE and no mem_resp is issued.
- pmem_read and pmem_write are never asserted together; each stays high until pmem_resp.
- Reset during S_WRITEBACK/S_ALLOCATE: immediate return to S_IDLE; pmem_* deassert asynchronously; partially fetched lines stay invalid.
- mem_rdata is 0 whenever mem_resp=0.

Optional Feature:
- Macro: DCACHE_MMIO_BYPASS_EN.
- Defined:
  - Addresses 0xFFE0–0xFFFF (the counter/MMIO window) are uncached.
  - A request there gets mem_resp=1 in the same cycle, mem_rdata=0x0000.
  - No array or state change; no hit/miss pulse; no pmem traffic.
- Undefined: that window is cached like any other address.

Test Plan:
- Reset, read 0x0104 with L2 returning line word2=0xBEEF -> dcache_miss 1 cycle; pmem_read with pmem_address=0x0100 until pmem_resp; next cycle mem_resp=1, mem_rdata=0xBEEF, dcache_hit=1.
- Write 0xA5A5, mask 11, to 0x0104 after the fill -> same-cycle mem_resp; following read of 0x0104 returns 0xA5A5 with no pmem activity.
- Byte write mask 10, data 0x7700, to 0x0104 -> subsequent read returns 0x77A5.
- Read 0x0184 (NUM_SETS=8, same index as 0x0104, different tag) with the line dirty -> pmem_write at address 0x0100 whose wdata word2=0x77A5, then pmem_read at 0x0180, then hit.
- Assert reset while in S_ALLOCATE -> pmem_read drops without a clock edge; a re-read of 0x0104 misses.
- With DCACHE_MMIO_BYPASS_EN defined, read 0xFFF9 -> same-cycle mem_resp, mem_rdata=0, no dcache_hit/dcache_miss, no pmem_read.

Source files
------------

// File: rtl/l1_dcache_responder.sv
// l1_dcache_responder: direct-mapped, write-back, write-allocate L1 data cache.
// It answers the mem stage with 16-bit words and fetches or writes back
// whole 128-bit lines toward L2.
// Optional feature: define DCACHE_MMIO_BYPASS_EN to make 0xFFE0-0xFFFF uncached.
// In that window reads return 0, and no state changes and no pulses occur.
module l1_dcache_responder #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output logic         dcache_hit,
  output logic         dcache_miss
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic [127:0]        data_q [NUM_SETS];
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  // Line address of the request that missed. Fill and writeback use this
  // address, so a requester that drops or changes its address mid-miss
  // cannot corrupt the transfer.
  logic [11:0]         line_q, line_d;

  logic [IW-1:0] idx, idx_m;
  logic [TW-1:0] tag, tag_m;
  logic [2:0]    off;
  logic [6:0]    lo_bit, hi_bit;
  logic          req, tag_hit, mmio, wr_hit, fill;
  logic [127:0]  cur_line;
  logic          unused_addr0;

  assign idx          = mem_address[3+IW:4];
  assign tag          = mem_address[15:4+IW];
  assign off          = mem_address[3:1];
  assign lo_bit       = {off, 4'b0000};
  assign hi_bit       = {off, 4'b1000};
  assign idx_m        = line_q[IW-1:0];
  assign tag_m        = line_q[11:IW];
  assign req          = mem_read | mem_write;
  assign cur_line     = data_q[idx];
  assign tag_hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr0 = mem_address[0];

`ifdef DCACHE_MMIO_BYPASS_EN
  assign mmio = (mem_address[15:5] == 11'h7FF);
`else
  assign mmio = 1'b0;
`endif

  // Next-state logic and outputs. Outputs are all zero unless a state drives them.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_d       = line_q;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    dcache_hit   = 1'b0;
    dcache_miss  = 1'b0;
    wr_hit       = 1'b0;
    fill         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !reset) begin
          if (mmio) begin
            mem_resp = 1'b1;
          end else if (tag_hit) begin
            mem_resp   = 1'b1;
            mem_rdata  = cur_line[lo_bit +: 16];
            dcache_hit = 1'b1;
            // When read and write are both high, the request is handled as a write.
            if (mem_write && (mem_byte_enable != 2'b00)) begin
              wr_hit       = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            dcache_miss = 1'b1;
            line_d      = mem_address[15:4];
            state_d     = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx_m], idx_m, 4'b0000};
        pmem_wdata   = data_q[idx_m];
        if (pmem_resp) begin
          dirty_d[idx_m] = 1'b0;
          state_d        = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {line_q, 4'b0000};
        if (pmem_resp) begin
          fill           = 1'b1;
          valid_d[idx_m] = 1'b1;
          dirty_d[idx_m] = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state. An asynchronous reset drops any miss in flight,
  // and lines that were only partly fetched stay invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      line_q  <= line_d;
    end
  end

  // Data and tag arrays. A line fill writes the whole line; a write hit
  // updates only the byte lanes whose enable bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx_m] <= pmem_rdata;
      tag_q[idx_m]  <= tag_m;
    end else if (wr_hit) begin
      if (mem_byte_enable[0]) data_q[idx][lo_bit +: 8] <= mem_wdata[7:0];
      if (mem_byte_enable[1]) data_q[idx][hi_bit +: 8] <= mem_wdata[15:8];
    end
  end
endmodule

// File: tb/tb_l1_dcache_responder.sv
// Directed bench with a scoreboard. Each request pushes its expected response
// into a queue, and a monitor pops and compares an entry on every mem_resp.
// A small L2 model with a three-cycle latency serves fills and writebacks.
module tb_l1_dcache_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
  logic         mem_read, mem_write, mem_resp;
  logic [1:0]   mem_byte_enable;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic         dcache_hit, dcache_miss;

  l1_dcache_responder #(.NUM_SETS(8)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .dcache_hit(dcache_hit), .dcache_miss(dcache_miss)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int hit_cnt = 0, miss_cnt = 0, both_cnt = 0, rdata_nz = 0;
  int n_rd = 0, n_wr = 0, rd_at_wr = -1;
  logic [15:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wdata = '0;
  logic [127:0] l2 [logic [15:0]];
  logic [16:0]  exp_q [$];   // {check_data, expected rdata}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts the event pulses, watches the protocol rules,
  // and pops the scoreboard on each response.
  always @(negedge clk) begin
    logic [16:0] e;
    hit_cnt  += int'(dcache_hit);
    miss_cnt += int'(dcache_miss);
    if (pmem_read && pmem_write) both_cnt++;
    if (mem_resp) begin
      if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        if (e[16]) check("rdata", mem_rdata, e[15:0]);
      end
    end else if (mem_rdata !== 16'h0) rdata_nz++;
  end

  // L2 model: completes each pmem request three cycles after it appears.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (reset) cnt = 0;
      else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            l2[pmem_address] = pmem_wdata;
            last_wr_addr = pmem_address;
            last_wdata   = pmem_wdata;
            rd_at_wr     = n_rd;
            n_wr++;
          end else begin
            pmem_rdata   = l2.exists(pmem_address) ? l2[pmem_address] : 128'h0;
            last_rd_addr = pmem_address;
            n_rd++;
          end
        end
      end
    end
  end

  task automatic do_req(input logic [15:0] a, input logic wr, input logic [15:0] d,
                        input logic [1:0] be, input logic [16:0] exp, output int lat);
    exp_q.push_back(exp);
    mem_address = a; mem_write = wr; mem_read = !wr;
    mem_wdata = d; mem_byte_enable = be;
    lat = 0;
    @(negedge clk);
    while (!mem_resp && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    if (!mem_resp) begin
      check("req_timeout", 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int lat, w;
    int h0, m0, r0;
    l2[16'h0100] = {80'h0, 16'hBEEF, 32'h0};
    l2[16'h0180] = {64'h0, 16'h0, 16'h1234, 16'h5678, 16'h0};
    mem_address = '0; mem_wdata = '0; mem_read = 0; mem_write = 0; mem_byte_enable = '0;
    reset = 1'b1;
    #2;
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_rw", {pmem_read, pmem_write}, 0);
    check("rst_pulses", {dcache_hit, dcache_miss}, 0);
    check("rst_rdata", mem_rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First read misses; the fill brings in word2 = BEEF.
    do_req(16'h0104, 0, 16'h0, 2'b00, {1'b1, 16'hBEEF}, lat);
    check("miss_lat_nonzero", lat > 0, 1);
    check("fill_addr", last_rd_addr, 16'h0100);
    check("miss_pulse_once", miss_cnt, 1);
    check("hit_after_fill", hit_cnt, 1);
    check("no_wb_clean", n_wr, 0);

    // A full-word write hit responds in the same cycle and the following read returns it.
    do_req(16'h0104, 1, 16'hA5A5, 2'b11, {1'b0, 16'h0}, lat);
    check("wr_hit_lat", lat, 0);
    do_req(16'h0104, 0, 16'h0, 2'b00, {1'b1, 16'hA5A5}, lat);
    check("rd_hit_lat", lat, 0);
    check("no_pmem_on_hits", n_rd, 1);
    // A write with only the upper lane enabled changes only bits [15:8].
    do_req(16'h0104, 1, 16'h7700, 2'b10, {1'b0, 16'h0}, lat);
    do_req(16'h0104, 0, 16'h0, 2'b00, {1'b1, 16'h77A5}, lat);
    // Mask 00 changes nothing, and read+write together is handled as a write.
    exp_q.push_back({1'b0, 16'h0});
    mem_address = 16'h0104; mem_read = 1; mem_write = 1; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b00;
    @(negedge clk);
    check("be00_same_cycle_resp", mem_resp, 1);
    @(posedge clk); #1 mem_read = 0; mem_write = 0;
    do_req(16'h0104, 0, 16'h0, 2'b00, {1'b1, 16'h77A5}, lat);

    // Conflicting tag with a dirty victim: writeback first, then fill.
    do_req(16'h0184, 0, 16'h0, 2'b00, {1'b1, 16'h1234}, lat);
    check("wb_count", n_wr, 1);
    check("wb_addr", last_wr_addr, 16'h0100);
    check("wb_data", last_wdata, {80'h0, 16'h77A5, 32'h0});
    check("wb_before_fill", rd_at_wr, 1);
    check("fill2_addr", last_rd_addr, 16'h0180);
    check("fill2_count", n_rd, 2);
    do_req(16'h0182, 0, 16'h0, 2'b00, {1'b1, 16'h5678}, lat);
    check("same_line_hit_lat", lat, 0);

`ifdef DCACHE_MMIO_BYPASS_EN
    h0 = hit_cnt; m0 = miss_cnt; r0 = n_rd;
    do_req(16'hFFF9, 0, 16'h0, 2'b00, {1'b1, 16'h0000}, lat);
    check("mmio_lat", lat, 0);
    check("mmio_no_hit", hit_cnt, h0);
    check("mmio_no_miss", miss_cnt, m0);
    check("mmio_no_pmem", n_rd, r0);
`endif

    // Reset in S_ALLOCATE: pmem_read must drop without waiting for a clock edge.
    mem_address = 16'h0104; mem_read = 1; mem_write = 0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pmem_read && w < 20);
    check("alloc_reached", pmem_read, 1);
    #2 reset = 1'b1;
    #1 check("pmem_read_async_drop", pmem_read, 0);
    check("rst_mid_resp", mem_resp, 0);
    mem_read = 0;
    @(posedge clk); #3 reset = 1'b0;
    // The cache must miss again; L2 now holds the written-back 77A5.
    do_req(16'h0104, 0, 16'h0, 2'b00, {1'b1, 16'h77A5}, lat);
    check("rereset_miss_lat", lat > 0, 1);
    check("rereset_fill_count", n_rd, 3);
    check("rereset_fill_addr", last_rd_addr, 16'h0100);

    repeat (2) @(negedge clk);
    check("total_hits", hit_cnt, 10);
    check("total_misses", miss_cnt, 4);
    check("rw_never_both", both_cnt, 0);
    check("rdata_zero_idle", rdata_nz, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
